// File: rtl/sort_pkg.sv
// Shared types for the 9-nibble sorter datapath: the frame loader and the sorter FSM both import this.
package sort_pkg;
  localparam int W  = 4;
  localparam int N  = 9;
  localparam int CW = $clog2(N + 1);

  typedef logic [W-1:0] nibble_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } ldr_state_t;
endpackage

// File: rtl/sort_frame_loader_if.sv
// Bus between the sample producer / frame consumer (master) and the frame loader (slave).
// Optional frame_cnt signal present only when FRAME_CNT_EN is defined.
interface sort_frame_loader_if;
  import sort_pkg::*;

  // Sample handshake: a sample transfers on a clk edge where in_valid and in_ready are both 1.
  // in_data must be stable while in_valid is 1; in_ready never depends on in_valid.
  // Frame handshake: frame_out is stable while frame_valid is 1; frame_ack releases it.
  nibble_t          in_data;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  nibble_t          frame_out [N-1:0];
  logic             frame_valid;
  logic             frame_ack;
  logic [CW-1:0]    fill_level;
  ldr_state_t       state_dbg;
`ifdef FRAME_CNT_EN
  logic [7:0]       frame_cnt;
`endif

  modport master (
    output in_data, in_valid, flush, frame_ack,
    input  in_ready, frame_out, frame_valid, fill_level, state_dbg
`ifdef FRAME_CNT_EN
    , frame_cnt
`endif
  );

  modport slave (
    input  in_data, in_valid, flush, frame_ack,
    output in_ready, frame_out, frame_valid, fill_level, state_dbg
`ifdef FRAME_CNT_EN
    , frame_cnt
`endif
  );
endinterface

// File: rtl/sort_frame_loader.sv
// Serial-to-parallel frame loader for the nibble sorter: collects N samples, holds them until acked.
// Define FRAME_CNT_EN to add an 8-bit wrapping count of acked frames.
module sort_frame_loader
  import sort_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  sort_frame_loader_if.slave  bus
);

  ldr_state_t     state_q, state_d;
  logic [CW-1:0]  fill_q, fill_d;
  nibble_t        frame_q [N-1:0];
  nibble_t        frame_d [N-1:0];
  logic           in_ready_q, in_ready_d;
  logic           frame_valid_q, frame_valid_d;
  logic [CW-1:0]  wr_idx;
  logic           accept;
`ifdef FRAME_CNT_EN
  logic [7:0]     cnt_q, cnt_d;
`endif

  // First sample of a frame lands in the top entry, so the frame reads out in arrival order from N-1 down.
  assign wr_idx = CW'(N - 1) - fill_q;
  assign accept = bus.in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    frame_d = frame_q;
`ifdef FRAME_CNT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (bus.flush) begin
          fill_d = '0;
        end else if (accept) begin
          frame_d[wr_idx] = bus.in_data;
          fill_d          = fill_q + CW'(1);
          if (fill_q == CW'(N - 1)) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.flush) begin
          state_d = FILL;
          fill_d  = '0;
        end else if (bus.frame_ack) begin
          state_d = FILL;
          fill_d  = '0;
`ifdef FRAME_CNT_EN
          cnt_d   = cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d    = (state_d == FILL);
    frame_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      fill_q        <= '0;
      frame_q       <= '{default: '0};
      in_ready_q    <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_q        <= fill_d;
      frame_q       <= frame_d;
      in_ready_q    <= in_ready_d;
      frame_valid_q <= frame_valid_d;
    end
  end

`ifdef FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
  assign bus.frame_cnt = cnt_q;
`endif

  assign bus.in_ready    = in_ready_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.fill_level  = fill_q;
  assign bus.frame_out   = frame_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_sort_frame_loader.sv
// Self-checking bench for sort_frame_loader: directed frames, scoreboarded on frame_valid rise.
// Frame counter checks are compiled in when FRAME_CNT_EN is defined.
module tb_sort_frame_loader;
  import sort_pkg::*;

  localparam int FW = W * N;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sort_frame_loader_if bus ();

  sort_frame_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [FW-1:0] exp_q[$];
  logic fv_prev = 1'b0;

  function automatic logic [FW-1:0] pack_frame();
    logic [FW-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) p[i*W +: W] = bus.frame_out[i];
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every rising frame_valid must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      fv_prev = 1'b0;
    end else begin
      if (bus.frame_valid && !fv_prev) begin
        if (exp_q.size() == 0) check("unexpected_frame", 64'(pack_frame()), 64'hdead);
        else check("frame", 64'(pack_frame()), 64'(exp_q.pop_front()));
      end
      fv_prev = bus.frame_valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input nibble_t d);
    int  t;
    bit  ok;
    t  = 0;
    ok = 1'b0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    while (!ok && t < 50) begin
      @(negedge clk);
      ok = bus.in_ready;
      step();
      t++;
    end
    bus.in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'(ok), 64'd1);
  endtask

  task automatic do_ack();
    bus.frame_ack = 1'b1;
    step();
    bus.frame_ack = 1'b0;
    check("ack_fv", 64'(bus.frame_valid), 64'd0);
    check("ack_rdy", 64'(bus.in_ready), 64'd1);
    check("ack_fill", 64'(bus.fill_level), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   64'(bus.in_ready), 64'd0);
    check({tag, "_fv"},    64'(bus.frame_valid), 64'd0);
    check({tag, "_fill"},  64'(bus.fill_level), 64'd0);
    check({tag, "_frame"}, 64'(pack_frame()), 64'd0);
    check({tag, "_state"}, 64'(bus.state_dbg), 64'(IDLE));
`ifdef FRAME_CNT_EN
    check({tag, "_cnt"},   64'(bus.frame_cnt), 64'd0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.frame_ack = 1'b0;

    // Reset held for 3 clocks, then released
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("idle_rdy", 64'(bus.in_ready), 64'd0);
    step();
    check("post_rst_rdy", 64'(bus.in_ready), 64'd1);
    check("post_rst_fv", 64'(bus.frame_valid), 64'd0);

    // Back-to-back frame 9..1
    exp_q.push_back(36'h987654321);
    for (int k = 0; k < N; k++) begin
      send(nibble_t'(9 - k));
      check("fill_b2b", 64'(bus.fill_level), 64'(k + 1));
    end
    check("hold_fv", 64'(bus.frame_valid), 64'd1);
    check("hold_rdy", 64'(bus.in_ready), 64'd0);

    // HOLD ignores incoming samples
    bus.in_data  = 4'hF;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("hold_frame", 64'(pack_frame()), 64'h987654321);
      check("hold_fill", 64'(bus.fill_level), 64'd9);
      check("hold_fv2", 64'(bus.frame_valid), 64'd1);
    end
    bus.in_valid = 1'b0;

    // Ack, then all-A frame with random gaps
    do_ack();
    exp_q.push_back(36'hAAAAAAAAA);
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 2)) step();
      send(4'hA);
    end
    check("gap_fv", 64'(bus.frame_valid), 64'd1);
    do_ack();
`ifdef FRAME_CNT_EN
    check("cnt_2", 64'(bus.frame_cnt), 64'd2);
`endif

    // Partial frame with a stray ack, then flush with a sample presented
    bus.frame_ack = 1'b1;
    for (int k = 1; k <= 5; k++) send(nibble_t'(k));
    bus.frame_ack = 1'b0;
    check("stray_ack_fill", 64'(bus.fill_level), 64'd5);
    check("stray_ack_state", 64'(bus.state_dbg), 64'(FILL));
    bus.flush    = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hE;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_fill", 64'(bus.fill_level), 64'd0);
    check("flush_fv", 64'(bus.frame_valid), 64'd0);
    check("flush_rdy", 64'(bus.in_ready), 64'd1);
    exp_q.push_back(36'h123456789);
    for (int k = 1; k <= N; k++) send(nibble_t'(k));
    check("post_flush_fv", 64'(bus.frame_valid), 64'd1);

    // Flush out of HOLD: frame released without counting
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("hold_flush_fv", 64'(bus.frame_valid), 64'd0);
    check("hold_flush_fill", 64'(bus.fill_level), 64'd0);
    check("hold_flush_rdy", 64'(bus.in_ready), 64'd1);
`ifdef FRAME_CNT_EN
    check("cnt_flush", 64'(bus.frame_cnt), 64'd2);
`endif
    exp_q.push_back(36'h333333333);
    for (int k = 0; k < N; k++) send(4'h3);
    do_ack();
`ifdef FRAME_CNT_EN
    check("cnt_3", 64'(bus.frame_cnt), 64'd3);
`endif

    // Asynchronous reset mid-fill
    for (int k = 1; k <= 4; k++) send(nibble_t'(k));
    check("pre_async_fill", 64'(bus.fill_level), 64'd4);
    #3 rst = 1'b0;
    #1;
    check_reset_outputs("async");
    @(posedge clk);
    #1 rst = 1'b1;
    step();
    check("async_rel_rdy", 64'(bus.in_ready), 64'd1);

`ifdef FRAME_CNT_EN
    // 256 acked frames wrap the counter back to zero
    for (int f = 0; f < 256; f++) begin
      exp_q.push_back({N{f[3:0]}});
      for (int k = 0; k < N; k++) send(f[3:0]);
      bus.frame_ack = 1'b1;
      step();
      bus.frame_ack = 1'b0;
      if (f == 254) check("cnt_255", 64'(bus.frame_cnt), 64'd255);
    end
    check("cnt_wrap", 64'(bus.frame_cnt), 64'd0);
`endif

    repeat (3) step();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
